// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared types and defaults for the FIFO-to-stream drain block.
package fifo_stream_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 8;
    localparam int BUF_DEPTH  = 2;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
endpackage

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry buffer; head entry drives the stream, push and pop may coincide.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o
);
    logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]        cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
        if (pop_i && cnt_q == 2'd2) e0_d = e1_q;
        // an incoming word lands in the head only if the head is (or becomes) free
        if (push_i) begin
            if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop_i)) e0_d = data_i;
            else e1_d = data_i;
        end
        if (clr_i) begin
            e0_d  = '0;
            e1_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = e0_q;
    assign count_o = cnt_q;
endmodule

// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: pops a 1-cycle-latency FIFO into a stream with burst framing.
module fifo_stream_drain
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              hw_rst,
    input  logic              sw_rst,
    input  logic              enable,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              top_rd_en,
    input  logic [DATA_W-1:0] top_rd_data,
    input  logic              valid,
    input  logic              ext_mem_empty,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [LEN_W-1:0]  beat_cnt,
    output logic              busy,
    output logic              spurious_err
);
    state_e           state_q, state_d;
    logic             inflight_q, drop_q, err_q, err_d;
    logic [LEN_W-1:0] beat_q, beat_d, len_q, len_d, last_idx;
    logic [1:0]       occ;
    logic             push, pop;

    assign pop      = m_tvalid && m_tready;
    assign push     = valid && inflight_q && !sw_rst;
    assign m_tvalid = occ != 2'd0;
    // beat 0 uses the live burst_len since the length is only latched on that beat
    assign last_idx = (beat_q == '0 ? burst_len : len_q) - LEN_W'(1);
    assign m_tlast  = m_tvalid && beat_q == last_idx;
    // credit counts the slot freed by this cycle's handshake so a full-rate stream never bubbles
    assign top_rd_en = state_q == RUN && !ext_mem_empty && !sw_rst &&
                       (occ - 2'(pop) + 2'(inflight_q)) < 2'(BUF_DEPTH);
    assign busy         = state_q != IDLE;
    assign beat_cnt     = beat_q;
    assign spurious_err = err_q;

    stream_skid_buf #(.DATA_W(DATA_W)) u_buf (
        .clk     (clk),
        .rst     (hw_rst),
        .clr_i   (sw_rst),
        .push_i  (push),
        .data_i  (top_rd_data),
        .pop_i   (pop),
        .head_o  (m_tdata),
        .count_o (occ)
    );

    always_comb begin
        state_d = sw_rst ? IDLE :
                  state_q == IDLE ? (enable ? RUN : IDLE) :
                  enable ? RUN :
                  (state_q == RUN || occ != 2'd0 || inflight_q) ? DRAIN : IDLE;
        beat_d  = sw_rst ? '0 : pop ? (m_tlast ? '0 : beat_q + LEN_W'(1)) : beat_q;
        len_d   = sw_rst ? '0 : (pop && beat_q == '0) ? burst_len : len_q;
        err_d   = !sw_rst && (err_q || (valid && !inflight_q && !drop_q));
    end

    // drop_q masks a read response that was already committed when a reset hit
    always_ff @(posedge clk or posedge hw_rst) begin
        if (hw_rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            drop_q     <= 1'b1;
            err_q      <= 1'b0;
            beat_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= top_rd_en;
            drop_q     <= sw_rst;
            err_q      <= err_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
        end
    end
endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: directed checks of the FIFO-to-stream drain block.
module tb_fifo_stream_drain;
    localparam int DW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0, hw_rst = 1'b1, sw_rst = 1'b0, enable = 1'b0, m_tready = 1'b0;
    logic          fifo_valid = 1'b0, inj_valid = 1'b0, rd_s = 1'b0, chk_bp = 1'b0;
    logic [LW-1:0] burst_len = 8'd4;
    logic [DW-1:0] top_rd_data = '0;
    logic          top_rd_en, valid, ext_mem_empty, m_tvalid, m_tlast, busy, spurious_err;
    logic [DW-1:0] m_tdata;
    logic [LW-1:0] beat_cnt;

    logic [DW-1:0] mem [0:1023];
    int            wr_ptr = 0, rd_ptr = 0;
    int            n_chk = 0, n_fail = 0;
    logic [DW-1:0] log_d [$];
    logic          log_l [$];
    logic [LW-1:0] log_b [$];
    int            log_t [$];
    int            cyc_n = 0, occ = 0, bp_max = 0, bp_unstable = 0, bp_tvbad = 0, bp_stalls = 0;
    logic          stall_q = 1'b0, stall_l = 1'b0;
    logic [DW-1:0] stall_d = '0;

    assign valid         = fifo_valid | inj_valid;
    assign ext_mem_empty = (rd_ptr == wr_ptr);

    fifo_stream_drain #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .hw_rst(hw_rst), .sw_rst(sw_rst), .enable(enable), .burst_len(burst_len),
        .top_rd_en(top_rd_en), .top_rd_data(top_rd_data), .valid(valid), .ext_mem_empty(ext_mem_empty),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .beat_cnt(beat_cnt), .busy(busy), .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    // FIFO model: a pop seen in cycle N returns its word in cycle N+1
    always @(negedge clk) rd_s = top_rd_en;
    always @(posedge clk) begin
        #1;
        fifo_valid = rd_s;
        if (rd_s) begin
            top_rd_data = mem[rd_ptr % 1024];
            rd_ptr++;
        end
    end

    // stream sink and backpressure observer
    always @(negedge clk) begin
        cyc_n++;
        if (!hw_rst && !sw_rst && m_tvalid && m_tready) begin
            log_d.push_back(m_tdata);
            log_l.push_back(m_tlast);
            log_b.push_back(beat_cnt);
            log_t.push_back(cyc_n);
        end
        if (chk_bp) begin
            if (m_tvalid !== (occ > 0)) bp_tvbad++;
            if (stall_q && (m_tdata !== stall_d || m_tlast !== stall_l)) bp_unstable++;
            occ = occ + int'(fifo_valid) - int'(m_tvalid && m_tready);
            if (occ + int'(top_rd_en) > bp_max) bp_max = occ + int'(top_rd_en);
            stall_q = m_tvalid && !m_tready;
            if (stall_q) bp_stalls++;
            stall_d = m_tdata;
            stall_l = m_tlast;
        end else begin
            occ = 0; bp_max = 0; bp_unstable = 0; bp_tvbad = 0; bp_stalls = 0; stall_q = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_words(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 1024] = first + DW'(i);
            wr_ptr++;
        end
    endtask

    task automatic wait_log(input int target, input int limit);
        int k = 0;
        while (log_d.size() < target && k < limit) begin tick(1); k++; end
        n_chk++;
        if (log_d.size() < target) begin
            n_fail++;
            $display("FAIL wait_beats: got %0d beats, need %0d", log_d.size(), target);
        end
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy && k < limit) begin tick(1); k++; end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_idle: busy=%b, need 0", busy); end
    endtask

    task automatic test_reset();
        tick(2);
        n_chk += 7;
        if (top_rd_en !== 1'b0)    begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", top_rd_en); end
        if (m_tvalid !== 1'b0)     begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        if (m_tlast !== 1'b0)      begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
        if (m_tdata !== '0)        begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
        if (beat_cnt !== '0)       begin n_fail++; $display("FAIL reset_beat: got %0d want 0", beat_cnt); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (spurious_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", spurious_err); end
        hw_rst = 1'b0;
        tick(2);
    endtask

    task automatic test_throughput();
        int base = log_d.size();
        push_words(32'h1, 8);
        burst_len = 8'd4; m_tready = 1'b1; enable = 1'b1;
        wait_log(base + 8, 60);
        enable = 1'b0;
        wait_idle(20);
        for (int i = 0; i < 8 && base + i < log_d.size(); i++) begin
            n_chk += 3;
            if (log_d[base+i] !== DW'(i + 1)) begin n_fail++; $display("FAIL thr_data[%0d]: got %h want %h", i, log_d[base+i], i + 1); end
            if (log_l[base+i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL thr_last[%0d]: got %b want %b", i, log_l[base+i], i % 4 == 3); end
            if (log_b[base+i] !== LW'(i % 4)) begin n_fail++; $display("FAIL thr_beat[%0d]: got %0d want %0d", i, log_b[base+i], i % 4); end
            if (i > 0) begin
                n_chk++;
                if (log_t[base+i] - log_t[base+i-1] !== 1) begin n_fail++; $display("FAIL thr_gap[%0d]: got %0d cycles want 1", i, log_t[base+i] - log_t[base+i-1]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int base = log_d.size();
        int k = 0;
        logic [3:0] pat = 4'b1001;
        push_words(32'h11, 8);
        burst_len = 8'd4; chk_bp = 1'b1; enable = 1'b1;
        while (log_d.size() < base + 8 && k < 200) begin
            m_tready = pat[k % 4];
            tick(1);
            k++;
        end
        n_chk++;
        if (log_d.size() < base + 8) begin n_fail++; $display("FAIL bp_beats: got %0d want 8", log_d.size() - base); end
        enable = 1'b0; m_tready = 1'b1;
        wait_idle(20);
        n_chk += 4;
        if (bp_max > 2)       begin n_fail++; $display("FAIL bp_credit: got occupancy+inflight %0d want <=2", bp_max); end
        if (bp_unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled want 0", bp_unstable); end
        if (bp_tvbad !== 0)    begin n_fail++; $display("FAIL bp_tvalid: got %0d tvalid/occupancy disagreements want 0", bp_tvbad); end
        if (bp_stalls == 0)    begin n_fail++; $display("FAIL bp_stalls: got 0 stalled cycles want >0"); end
        chk_bp = 1'b0;
        for (int i = 0; i < 8 && base + i < log_d.size(); i++) begin
            n_chk += 3;
            if (log_d[base+i] !== DW'(32'h11 + i)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, log_d[base+i], 32'h11 + i); end
            if (log_l[base+i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b want %b", i, log_l[base+i], i % 4 == 3); end
            if (log_b[base+i] !== LW'(i % 4)) begin n_fail++; $display("FAIL bp_beat[%0d]: got %0d want %0d", i, log_b[base+i], i % 4); end
        end
    endtask

    task automatic test_pause();
        int base = log_d.size();
        int k = 0;
        int n1;
        push_words(32'h21, 8);
        burst_len = 8'd4; m_tready = 1'b1; enable = 1'b1;
        while (log_d.size() < base + 2 && k < 40) begin tick(1); k++; end
        enable = 1'b0;
        wait_idle(20);
        n1 = log_d.size() - base;
        n_chk += 2;
        if (n1 <= 2 || n1 >= 8) begin n_fail++; $display("FAIL pause_drained: got %0d beats before idle want 3..7", n1); end
        if (beat_cnt !== LW'(n1 % 4)) begin n_fail++; $display("FAIL pause_beat: got %0d want %0d", beat_cnt, n1 % 4); end
        enable = 1'b1;
        wait_log(base + 8, 40);
        enable = 1'b0;
        wait_idle(20);
        for (int i = 0; i < 8 && base + i < log_d.size(); i++) begin
            n_chk += 3;
            if (log_d[base+i] !== DW'(32'h21 + i)) begin n_fail++; $display("FAIL pause_data[%0d]: got %h want %h", i, log_d[base+i], 32'h21 + i); end
            if (log_l[base+i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL pause_last[%0d]: got %b want %b", i, log_l[base+i], i % 4 == 3); end
            if (log_b[base+i] !== LW'(i % 4)) begin n_fail++; $display("FAIL pause_beat[%0d]: got %0d want %0d", i, log_b[base+i], i % 4); end
        end
    endtask

    task automatic test_len_zero();
        int base = log_d.size();
        int k = 0;
        push_words(32'h1000, 256);
        burst_len = 8'd0; m_tready = 1'b1; enable = 1'b1;
        while (log_d.size() < base + 1 && k < 20) begin tick(1); k++; end
        burst_len = 8'd4;
        wait_log(base + 256, 400);
        enable = 1'b0;
        wait_idle(20);
        for (int i = 0; i < 256 && base + i < log_d.size(); i++) begin
            n_chk += 3;
            if (log_d[base+i] !== DW'(32'h1000 + i)) begin n_fail++; $display("FAIL len0_data[%0d]: got %h want %h", i, log_d[base+i], 32'h1000 + i); end
            if (log_l[base+i] !== (i == 255)) begin n_fail++; $display("FAIL len0_last[%0d]: got %b want %b", i, log_l[base+i], i == 255); end
            if (log_b[base+i] !== LW'(i)) begin n_fail++; $display("FAIL len0_beat[%0d]: got %0d want %0d", i, log_b[base+i], i); end
        end
        n_chk++;
        if (beat_cnt !== '0) begin n_fail++; $display("FAIL len0_wrap: got %0d want 0", beat_cnt); end
    endtask

    task automatic test_sw_rst();
        int base = log_d.size();
        push_words(32'h31, 4);
        burst_len = 8'd4; m_tready = 1'b0; enable = 1'b1;
        tick(6);
        n_chk++;
        if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL swr_prefill: got tvalid %b want 1", m_tvalid); end
        sw_rst = 1'b1; enable = 1'b0;
        tick(1);
        sw_rst = 1'b0; inj_valid = 1'b1;
        n_chk += 5;
        if (m_tvalid !== 1'b0)  begin n_fail++; $display("FAIL swr_tvalid: got %b want 0", m_tvalid); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL swr_busy: got %b want 0", busy); end
        if (m_tdata !== '0)     begin n_fail++; $display("FAIL swr_tdata: got %h want 0", m_tdata); end
        if (beat_cnt !== '0)    begin n_fail++; $display("FAIL swr_beat: got %0d want 0", beat_cnt); end
        if (top_rd_en !== 1'b0) begin n_fail++; $display("FAIL swr_rd_en: got %b want 0", top_rd_en); end
        tick(1);
        inj_valid = 1'b0;
        tick(1);
        n_chk++;
        if (spurious_err !== 1'b0) begin n_fail++; $display("FAIL swr_err: got %b want 0", spurious_err); end
        m_tready = 1'b1; enable = 1'b1;
        wait_log(base + 2, 30);
        enable = 1'b0;
        wait_idle(20);
        if (log_d.size() >= base + 2) begin
            n_chk += 2;
            if (log_d[base] !== 32'h33)   begin n_fail++; $display("FAIL swr_next0: got %h want 33", log_d[base]); end
            if (log_d[base+1] !== 32'h34) begin n_fail++; $display("FAIL swr_next1: got %h want 34", log_d[base+1]); end
        end
    endtask

    task automatic test_error();
        tick(2);
        inj_valid = 1'b1;
        tick(1);
        inj_valid = 1'b0;
        n_chk += 2;
        if (spurious_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", spurious_err); end
        if (m_tvalid !== 1'b0)     begin n_fail++; $display("FAIL err_tvalid: got %b want 0", m_tvalid); end
        tick(4);
        n_chk += 2;
        if (spurious_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", spurious_err); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL err_busy: got %b want 0", busy); end
    endtask

    task automatic test_hw_rst_mid();
        push_words(32'h41, 4);
        burst_len = 8'd4; m_tready = 1'b0; enable = 1'b1;
        tick(6);
        n_chk += 2;
        if (m_tvalid !== 1'b1)   begin n_fail++; $display("FAIL hwr_prefill: got tvalid %b want 1", m_tvalid); end
        if (beat_cnt !== 8'd2)   begin n_fail++; $display("FAIL hwr_prebeat: got %0d want 2", beat_cnt); end
        hw_rst = 1'b1;
        #1;
        n_chk += 7;
        if (top_rd_en !== 1'b0)    begin n_fail++; $display("FAIL hwr_rd_en: got %b want 0", top_rd_en); end
        if (m_tvalid !== 1'b0)     begin n_fail++; $display("FAIL hwr_tvalid: got %b want 0", m_tvalid); end
        if (m_tlast !== 1'b0)      begin n_fail++; $display("FAIL hwr_tlast: got %b want 0", m_tlast); end
        if (m_tdata !== '0)        begin n_fail++; $display("FAIL hwr_tdata: got %h want 0", m_tdata); end
        if (beat_cnt !== '0)       begin n_fail++; $display("FAIL hwr_beat: got %0d want 0", beat_cnt); end
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL hwr_busy: got %b want 0", busy); end
        if (spurious_err !== 1'b0) begin n_fail++; $display("FAIL hwr_err: got %b want 0", spurious_err); end
        enable = 1'b0;
        tick(2);
        hw_rst = 1'b0;
        tick(3);
        n_chk += 2;
        if (spurious_err !== 1'b0) begin n_fail++; $display("FAIL hwr_post_err: got %b want 0", spurious_err); end
        if (m_tvalid !== 1'b0)     begin n_fail++; $display("FAIL hwr_post_tvalid: got %b want 0", m_tvalid); end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_backpressure();
        test_pause();
        test_len_zero();
        test_sw_rst();
        test_error();
        test_hw_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
